cpu_seq_ctrl: RTL
=================

Name: cpu_seq_ctrl

Overview:
- Multi-cycle sequencer between instruction memory, the combinational instruction decoder, the ALU/shifter datapath and the register file.
- Fetches an instruction with a req/ready handshake and latches it into IR, which feeds the decoder.
- Steps each instruction through DECODE, EXEC and WB (or BRANCH); clo/clz get a configurable multi-cycle EXEC.
- Gates register writes and PC updates, suppresses writeback on signed overflow, and halts on illegal opcodes.

Parameters:
- CLZ_LAT, 4, EXEC cycles for clo/clz (1..15).
- IW, 32, instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  when high, FETCH does not issue a new request.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction valid this cycle.
- imem_rdata  in  IW  fetched instruction.
- overflow  in  1  ALU signed overflow, valid in EXEC and WB.
- branch_taken  in  1  branch condition result, valid in BRANCH.
- ir  out  IW  latched instruction, drives the decoder.
- reg_we  out  4  register-file byte write enables.
- pc_en  out  1  PC update strobe.
- pc_sel  out  2  next-PC select: 00 = PC+4, 01 = jump target, 10 = branch target.
- state  out  3  current FSM state.
- ovf_flag  out  1  sticky: an overflowing writeback was suppressed.
- illegal  out  1  sticky: illegal opcode seen, core halted.

Behaviour:
- Reset (async, rst_n = 0): state = FETCH; ir, reg_we, pc_en, pc_sel, imem_req, ovf_flag, illegal and the exec counter all 0.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, WB = 3, BRANCH = 4, TRAP = 5.
- FETCH:
  - imem_req = !hold.
  - When imem_req and imem_ready in the same cycle: ir <= imem_rdata, go to DECODE.
  - imem_req stays high until ready.
  - If hold rises while a request is pending, imem_req drops and nothing is latched.
- DECODE (1 cycle), classifies ir:
  - Opcode 000000 with funct in {100000, 100010, 100011, 000111, 101011, 000010} -> EXEC.
  - Opcodes 001000, 001001, 001110, 001010, 001111, 011111 -> EXEC.
  - Opcode 011100 with funct 100001 or 100000 (clo/clz) -> EXEC, counter loaded with CLZ_LAT-1.
  - Opcodes 000010 and 000001 -> BRANCH.
  - Anything else -> TRAP.
- EXEC:
  - If counter != 0, decrement and stay.
  - Else go to WB. Non-clo/clz instructions spend exactly 1 cycle here.
- WB (1 cycle):
  - pc_en = 1, pc_sel = 00.
  - reg_we = 1111, except 0000 when overflow = 1 and the instruction is add, sub or addi; in that case ovf_flag <= 1.
  - subu and addiu ignore overflow.
  - Next state FETCH.
- BRANCH (1 cycle):
  - pc_en = 1, reg_we = 0000.
  - For j (000010): pc_sel = 01.
  - For 000001: pc_sel = 10 if branch_taken, else 00.
  - Next state FETCH.
- TRAP:
  - illegal <= 1; all strobes 0; imem_req 0.
  - Stays in TRAP until reset.
- Strobes: reg_we, pc_en and pc_sel are registered-state decodes, asserted only in WB or BRANCH and 0 in every other state.
- Latency with a zero-wait imem: ALU instruction = 4 cycles; branch/jump = 3 cycles; clo/clz = 3 + CLZ_LAT cycles.
- The sticky flags clear only on reset.
- Reset asserted mid-instruction aborts it: no partial writeback, and execution restarts in FETCH.

Optional Feature:
- Macro: CPU_SEQ_ICOUNT_EN.
- Defined: adds output retired_cnt [31:0], reset 0. It increments by 1 on each WB or BRANCH cycle and wraps from 0xFFFFFFFF to 0. Suppressed-overflow writebacks still count.
- Undefined: no port and no counter logic.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum/localparams;
  - opcode constants OP_RTYPE, OP_ADDI, OP_ADDIU, OP_XORI, OP_SLTI, OP_LUI, OP_SPEC2, OP_SEB, OP_J, OP_REGIMM;
  - funct constants;
  - pc_sel encodings.
- One sub-module, cpu_seq_classify: purely combinational, ir -> {is_alu, is_multi, is_branch, is_jump, ovf_trap_op, is_illegal}.

Test Plan:
- imem_ready tied 1, ir = 0x00221820 (add), overflow = 0 -> reg_we = 1111 exactly in cycle 4, pc_sel = 00, pc_en = 1.
- add with overflow = 1 in WB -> reg_we = 0000, ovf_flag = 1 and stays 1 across the following addiu.
- clo (0x70201821) with CLZ_LAT = 4 -> EXEC lasts 4 cycles, WB reached at cycle 7.
- j (0x08000010) -> BRANCH with pc_sel = 01; regimm with branch_taken = 0 -> pc_sel = 00, reg_we never nonzero.
- imem_ready low for 3 cycles, hold pulsed during the wait -> imem_req drops while hold = 1, ir unchanged until the accepting handshake.
- Opcode 0x3F in the fetched word -> TRAP, illegal = 1, imem_req stays 0. rst_n low mid-EXEC -> all outputs 0 immediately, FETCH after release.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the cpu_seq_ctrl instruction sequencer: FSM states,
// opcode/funct constants and next-PC select encodings.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_BRANCH = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_SPEC2  = 6'b011100;
  localparam logic [5:0] OP_SEB    = 6'b011111;

  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_CLZ  = 6'b100000;
  localparam logic [5:0] FN_CLO  = 6'b100001;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/cpu_seq_classify.sv
// Combinational instruction classifier: maps the latched IR onto the
// sequencer's instruction classes.
module cpu_seq_classify #(
  parameter int IW = 32
) (
  input  logic [IW-1:0] ir,
  output logic          is_alu,
  output logic          is_multi,
  output logic          is_branch,
  output logic          is_jump,
  output logic          ovf_trap_op,
  output logic          is_illegal
);
  import cpu_seq_pkg::*;

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_ir;

  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign unused_ir = ^ir;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    is_alu      = 1'b0;
    is_multi    = 1'b0;
    is_branch   = 1'b0;
    is_jump     = 1'b0;
    ovf_trap_op = 1'b0;
    is_illegal  = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB: begin
            is_alu      = 1'b1;
            ovf_trap_op = 1'b1;
          end
          FN_SUBU, FN_SRAV, FN_SLTU, FN_SRL: is_alu = 1'b1;
          default: is_illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        is_alu      = 1'b1;
        ovf_trap_op = 1'b1;
      end
      OP_ADDIU, OP_XORI, OP_SLTI, OP_LUI, OP_SEB: is_alu = 1'b1;
      OP_SPEC2: begin
        if (fn == FN_CLO || fn == FN_CLZ) is_multi   = 1'b1;
        else                              is_illegal = 1'b1;
      end
      OP_J:      is_jump    = 1'b1;
      OP_REGIMM: is_branch  = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/WB/BRANCH/TRAP.
// Optional retired-instruction counter enabled by defining CPU_SEQ_ICOUNT_EN.
module cpu_seq_ctrl #(
  parameter int CLZ_LAT = 4,
  parameter int IW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  output logic          imem_req,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_rdata,
  input  logic          overflow,
  input  logic          branch_taken,
  output logic [IW-1:0] ir,
  output logic [3:0]    reg_we,
  output logic          pc_en,
  output logic [1:0]    pc_sel,
  output logic [2:0]    state,
  output logic          ovf_flag,
  output logic          illegal
`ifdef CPU_SEQ_ICOUNT_EN
  ,
  output logic [31:0]   retired_cnt
`endif
);
  import cpu_seq_pkg::*;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             is_alu, is_multi, is_branch, is_jump, ovf_trap_op, is_illegal;
  logic             wb_suppress;

  cpu_seq_classify #(.IW(IW)) u_classify (
    .ir          (ir),
    .is_alu      (is_alu),
    .is_multi    (is_multi),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .ovf_trap_op (ovf_trap_op),
    .is_illegal  (is_illegal)
  );

  assign state       = st;
  assign wb_suppress = (st == S_WB) && ovf_trap_op && overflow;
  // NOTE: rst_n gates the request so it reads 0 throughout reset, not just after the first edge.
  assign imem_req    = rst_n && (st == S_FETCH) && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_FETCH;
      ir       <= '0;
      cnt      <= '0;
      ovf_flag <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (st)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir <= imem_rdata;
            st <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_illegal) begin
            st <= S_TRAP;
          end else if (is_multi) begin
            cnt <= CNT_W'(CLZ_LAT - 1);
            st  <= S_EXEC;
          end else if (is_alu) begin
            cnt <= '0;
            st  <= S_EXEC;
          end else if (is_jump || is_branch) begin
            st <= S_BRANCH;
          end else begin
            st <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           st  <= S_WB;
        end
        S_WB: begin
          if (wb_suppress) ovf_flag <= 1'b1;
          st <= S_FETCH;
        end
        S_BRANCH: st      <= S_FETCH;
        S_TRAP:   illegal <= 1'b1;
        default:  st      <= S_FETCH;
      endcase
    end
  end

  // Strobes decode straight from the state register so branch_taken and
  // overflow are used in the cycle they are valid.
  always_comb begin
    reg_we = 4'b0000;
    pc_en  = 1'b0;
    pc_sel = PC_SEL_SEQ;
    case (st)
      S_WB: begin
        pc_en  = 1'b1;
        reg_we = wb_suppress ? 4'b0000 : 4'b1111;
      end
      S_BRANCH: begin
        pc_en = 1'b1;
        if (is_jump)           pc_sel = PC_SEL_JUMP;
        else if (branch_taken) pc_sel = PC_SEL_BRANCH;
      end
      default: ;
    endcase
  end

`ifdef CPU_SEQ_ICOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           retired_cnt <= '0;
    else if (st == S_WB || st == S_BRANCH) retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule
